// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding and the fixed block/word/memory-address widths.
package instruction_cache_pkg;

  localparam int BLOCK_WIDTH    = 128;
  localparam int WORD_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } icache_state_t;

endpackage

// File: rtl/instruction_cache_word_select.sv
// 4:1 word multiplexer: picks one 32-bit instruction word out of a 128-bit
// cache block by word offset (word 0 lives in bits [31:0]).
module icache_word_select
  import instruction_cache_pkg::*;
(
  input  logic [BLOCK_WIDTH-1:0] block,
  input  logic [1:0]             offset,
  output logic [WORD_WIDTH-1:0]  word
);

  // Select the addressed word of the block
  always_comb begin
    word = block[WORD_WIDTH-1:0];
    case (offset)
      2'd0: word = block[0*WORD_WIDTH +: WORD_WIDTH];
      2'd1: word = block[1*WORD_WIDTH +: WORD_WIDTH];
      2'd2: word = block[2*WORD_WIDTH +: WORD_WIDTH];
      2'd3: word = block[3*WORD_WIDTH +: WORD_WIDTH];
      default: word = block[0*WORD_WIDTH +: WORD_WIDTH];
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with NUM_SETS lines of one
// 128-bit block each. Hits return the word combinationally with no stall;
// a miss stalls the CPU, reads the whole block from instruction memory,
// writes it into the line and lets the held fetch hit on the retry.
// Optional build macro ICACHE_PERF_COUNTERS_EN adds HIT_COUNT/MISS_COUNT.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [31:0]               PC,
  output logic [WORD_WIDTH-1:0]     INSTRUCTION,
  output logic                      BUSYWAIT,
  output logic                      MEM_READ,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0]    MEM_READDATA,
  input  logic                      MEM_BUSYWAIT
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]               HIT_COUNT,
  output logic [31:0]               MISS_COUNT
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = MEM_ADDR_WIDTH - IDX_W;

  icache_state_t state_q;

  logic [NUM_SETS-1:0]    valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [BLOCK_WIDTH-1:0] data_q [NUM_SETS];

  logic [BLOCK_WIDTH-1:0] fill_data_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       offset;
  logic             lookup_hit;
  logic             hit;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             unused_pc;

  assign idx       = PC[4 +: IDX_W];
  assign tag       = PC[31 -: TAG_W];
  assign offset    = PC[3:2];
  assign unused_pc = ^PC[1:0];

  // The latched block address carries both the fill index and the fill tag
  assign fill_idx = MEM_ADDRESS[IDX_W-1:0];
  assign fill_tag = MEM_ADDRESS[MEM_ADDR_WIDTH-1 -: TAG_W];

  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign hit        = (state_q == ST_IDLE) && lookup_hit;
  assign BUSYWAIT   = !hit;

  icache_word_select u_word_select (
    .block  (data_q[idx]),
    .offset (offset),
    .word   (INSTRUCTION)
  );

  // Control FSM: miss detection, memory request handshake, valid-bit update
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An unknown PC evaluates false here, so the FSM holds state
          if (!lookup_hit) begin
            state_q     <= ST_MEM_READ;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= PC[31:4];
          end
        end
        ST_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state_q  <= ST_UPDATE;
            MEM_READ <= 1'b0;
          end
        end
        ST_UPDATE: begin
          valid_q[fill_idx] <= 1'b1;
          state_q           <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          MEM_READ <= 1'b0;
        end
      endcase
    end
  end

  // Block capture and line write; data and tag storage are never reset
  always_ff @(posedge CLK) begin
    if (state_q == ST_MEM_READ && !MEM_BUSYWAIT) begin
      fill_data_q <= MEM_READDATA;
    end
    if (state_q == ST_UPDATE) begin
      data_q[fill_idx] <= fill_data_q;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic after_fill_q;

  // Hit/miss counters; the retry cycle right after a refill belongs to the
  // miss that caused it and is not counted as a hit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
      after_fill_q <= 1'b0;
    end else begin
      after_fill_q <= (state_q == ST_UPDATE);
      if (hit && !after_fill_q) begin
        HIT_COUNT <= HIT_COUNT + 32'd1;
      end
      if (state_q == ST_IDLE && !lookup_hit) begin
        MISS_COUNT <= MISS_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: a behavioural memory with programmable
// latency answers block reads, and a line-level model (which block address
// each set holds) predicts hit/miss, stall length and returned words.
module tb_instruction_cache;

  localparam int NUM_SETS = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 5;
  int mem_cnt = 0;

  logic [27:0] line_blk [NUM_SETS];
  bit          line_vld [NUM_SETS];

  instruction_cache #(.NUM_SETS(NUM_SETS)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory image: every word is a distinct function of block address and word
  function automatic logic [31:0] word_of(input logic [27:0] a, input int w);
    logic [1:0] wi;
    wi = w[1:0];
    return {a[23:0], 4'hC, wi, 2'b11} ^ {a[27:24], 28'h0};
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] a);
    return {word_of(a, 3), word_of(a, 2), word_of(a, 1), word_of(a, 0)};
  endfunction

  // Memory responder: data becomes valid after mem_lat cycles of MEM_READ
  always @(negedge CLK) begin
    if (MEM_READ === 1'b1) begin
      mem_cnt = mem_cnt + 1;
      MEM_BUSYWAIT = (mem_cnt < mem_lat);
      MEM_READDATA = MEM_BUSYWAIT ? ~block_of(MEM_ADDRESS) : block_of(MEM_ADDRESS);
    end else begin
      mem_cnt = 0;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_SETS; i++) begin
      line_vld[i] = 1'b0;
      line_blk[i] = '0;
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int lat, input bit wait_edge, input bit toggle);
    logic [27:0] blk;
    int          idx;
    bit          exp_hit;
    int          stall;
    blk = pc[31:4];
    idx = int'(blk) % NUM_SETS;
    exp_hit = line_vld[idx] && (line_blk[idx] == blk);
    mem_lat = lat;
    if (wait_edge) @(negedge CLK);
    PC = pc;
    #1;
    check("busy_first", {31'h0, BUSYWAIT}, {31'h0, !exp_hit});
    stall = 0;
    while (BUSYWAIT !== 1'b0 && stall < 64) begin
      if (MEM_READ === 1'b1) check("mem_address", {4'h0, MEM_ADDRESS}, {4'h0, blk});
      stall++;
      @(negedge CLK);
      PC = (toggle && MEM_READ === 1'b1) ? $urandom : pc;
      #1;
    end
    check("stall", 32'(stall), 32'(exp_hit ? 0 : lat + 2));
    check("instruction", INSTRUCTION, word_of(blk, int'(pc[3:2])));
    check("mem_read_idle", {31'h0, MEM_READ}, 32'h0);
    line_vld[idx] = 1'b1;
    line_blk[idx] = blk;
  endtask

  initial begin
    PC = 32'h0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    clear_model();
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_mem_read", {31'h0, MEM_READ}, 32'h0);
    check("rst_mem_address", {4'h0, MEM_ADDRESS}, 32'h0);
    check("rst_busywait", {31'h0, BUSYWAIT}, 32'h1);

    // Cold miss at 0x0 with latency 5, then the rest of the block hits
    @(negedge CLK);
    RESET = 1'b1;
    do_fetch(32'h0000_0000, 5, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 5, 1'b1, 1'b0);
    do_fetch(32'h0000_0008, 5, 1'b1, 1'b0);
    do_fetch(32'h0000_000C, 5, 1'b1, 1'b0);

    // Conflict on index 0: 0x80 evicts 0x0, then 0x0 misses again
    do_fetch(32'h0000_0080, 3, 1'b1, 1'b0);
    do_fetch(32'h0000_0000, 4, 1'b1, 1'b0);

    // PC wanders during a miss; only the latched block is filled
    do_fetch(32'h0000_0140, 6, 1'b1, 1'b1);
    do_fetch(32'h0000_0144, 2, 1'b1, 1'b0);

    // Reset in the middle of a fill abandons it
    @(negedge CLK);
    PC = 32'h0000_0250;
    mem_lat = 6;
    repeat (3) @(negedge CLK);
    #1;
    check("fill_started", {31'h0, MEM_READ}, 32'h1);
    RESET = 1'b0;
    #1;
    check("rst_mid_mem_read", {31'h0, MEM_READ}, 32'h0);
    check("rst_mid_mem_address", {4'h0, MEM_ADDRESS}, 32'h0);
    clear_model();
    @(negedge CLK);
    RESET = 1'b1;
    do_fetch(32'h0000_0250, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0000, 1, 1'b1, 1'b0);

    // Randomized fetch stream over a small address pool to mix hits/misses
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rpc;
      rpc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'h8000_0000;
      do_fetch(rpc, $urandom_range(1, 6), 1'b1, 1'($urandom_range(0, 1)));
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    @(negedge CLK);
    RESET = 1'b0;
    PC = 32'h0;
    clear_model();
    @(negedge CLK);
    RESET = 1'b1;
    do_fetch(32'h0000_0000, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 2, 1'b1, 1'b0);
    do_fetch(32'h0000_0080, 2, 1'b1, 1'b0);
    do_fetch(32'h0000_0000, 2, 1'b1, 1'b0);
    check("hit_count", hit_count, 32'd1);
    check("miss_count", miss_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter: NUM_SETS, 8, number of direct-mapped lines; power of two, 2..64.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  reset; asynchronous, active-low.
REQ-004 Port: PC  input  32  CPU fetch byte address; bits [1:0] ignored.
REQ-005 Port: INSTRUCTION  output  32  fetched instruction word.
REQ-006 Port: BUSYWAIT  output  1  high = CPU must stall and hold PC.
REQ-007 Port: MEM_READ  output  1  block read request to instruction memory.
REQ-008 Port: MEM_ADDRESS  output  28  block address, equal to PC[31:4] of the missing fetch.
REQ-009 Port: MEM_READDATA  input  128  fetched block; word 0 in bits [31:0].
REQ-010 Port: MEM_BUSYWAIT  input  1  memory busy; low with MEM_READ high = MEM_READDATA valid.

Function
REQ-011 Address split SHALL be: word offset PC[3:2]; index PC[3+log2(NUM_SETS):4]; tag = the remaining upper PC bits.
REQ-012 Storage per line SHALL be: valid bit, tag, and 128-bit data block.
REQ-013 FSM states SHALL be IDLE, MEM_READ, UPDATE.
REQ-014 IDLE hit (valid and tag match): INSTRUCTION = selected word combinationally; BUSYWAIT low; zero-cycle stall.
REQ-015 IDLE miss: BUSYWAIT high combinationally; next state MEM_READ; tag, index and block address latched.
REQ-016 MEM_READ: MEM_READ high; MEM_ADDRESS = latched block address; BUSYWAIT high.
REQ-017 MEM_READ exit: on the first rising edge where MEM_BUSYWAIT is sampled low, capture MEM_READDATA and go to UPDATE.
REQ-018 UPDATE: write block, tag and valid=1 into the latched index; MEM_READ low; BUSYWAIT high; next state IDLE unconditionally.
REQ-019 After UPDATE, the retried fetch SHALL hit in IDLE.
REQ-020 Miss penalty SHALL be: memory latency + 2 cycles.
REQ-021 PC changes while BUSYWAIT is high SHALL be ignored; the fill completes for the latched address.
REQ-022 MEM_READ SHALL be low in IDLE and UPDATE.
REQ-023 A refill SHALL overwrite the line unconditionally; there is no write path and no dirty state.
REQ-024 X or Z on PC while BUSYWAIT is low SHALL NOT corrupt stored state.

Reset
REQ-025 RESET low SHALL asynchronously: clear all valid bits; set state to IDLE; drive MEM_READ low and MEM_ADDRESS to 0.
REQ-026 Data and tag arrays SHALL NOT be reset.
REQ-027 Reset mid-fill SHALL abandon the fill; the line stays invalid; MEM_READ drops immediately.
REQ-028 After reset release, the first fetch SHALL always miss.

Configuration
REQ-029 Macro ICACHE_PERF_COUNTERS_EN defined: add outputs HIT_COUNT (32) and MISS_COUNT (32).
REQ-030 HIT_COUNT SHALL increment once per IDLE hit cycle; MISS_COUNT SHALL increment once per IDLE-to-MEM_READ transition.
REQ-031 Both counters SHALL wrap at 2^32 and clear on reset.
REQ-032 Macro undefined: the counter ports and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Shared package SHALL hold: FSM state encoding; BLOCK_WIDTH=128; WORD_WIDTH=32; MEM_ADDR_WIDTH=28.
REQ-034 One sub-module, icache_word_select: 4:1 word mux from a 128-bit block by offset.

Verification
REQ-035 Reset, then PC=0x00000000 with memory latency 5 -> BUSYWAIT high for 7 cycles; MEM_ADDRESS=0x0000000; then INSTRUCTION = block word 0.
REQ-036 After REQ-035, PC=0x4, 0x8, 0xC -> hits, zero stall, words 1-3 returned.
REQ-037 PC=0x80 (same index as 0x0 with NUM_SETS=8, different tag) -> miss, MEM_ADDRESS=0x0000008, line replaced; then PC=0x0 -> miss again.
REQ-038 PC toggled during an active miss -> MEM_ADDRESS stable; only the latched block is filled.
REQ-039 RESET pulsed low during MEM_READ -> MEM_READ drops asynchronously; the next fetch of the same PC misses.
REQ-040 With ICACHE_PERF_COUNTERS_EN defined, sequence 0x0, 0x4, 0x80, 0x0 -> HIT_COUNT=1, MISS_COUNT=3.
